// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } bin_bcd_state_t;

   // Double-dabble adjust: a digit at or above the threshold gets the offset
   // added before the shift so that it carries correctly into the next digit.
   localparam logic [3:0] BCD_ADJ_THR = 4'd5;
   localparam logic [3:0] BCD_ADJ     = 4'd3;

   // Decimal digits needed to show the largest magnitude a WIDTH-bit operand
   // can produce (2^(W-1) when signed, 2^W-1 when unsigned).
   function automatic int min_digits(input int width, input bit is_signed);
      longint unsigned max_mag;
      int              n;
      if (is_signed) max_mag = 64'd1 << (width - 1);
      else           max_mag = (64'd1 << width) - 64'd1;
      n = 1;
      while (max_mag > 64'd9) begin
         max_mag = max_mag / 64'd10;
         n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_dabble_cell.sv
// One BCD digit of the double-dabble chain: adjust, then shift left by one.
module bcd_dabble_cell
   import bin_bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       shift_i,
   output logic [3:0] digit_o,
   output logic       shift_o
);

   logic [3:0] adj;

   // Add 3 to digits of 5 or more, then shift the next lower bit in.
   always_comb begin
      adj     = (digit_i >= BCD_ADJ_THR) ? (digit_i + BCD_ADJ) : digit_i;
      digit_o = {adj[2:0], shift_i};
      shift_o = adj[3];
   end

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// start/done handshake, optional two's-complement input and overflow flag.
// Optional feature: define BIN_BCD_SEQ_BLANK_EN to add the leading-zero
// blanking output blank[DIGITS-1:0].
module bin_bcd_seq
   import bin_bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int SIGNED = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      in,
   output logic                  ready,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  negative,
   output logic                  overflow
`ifdef BIN_BCD_SEQ_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   // Too few digits is legal: the overflow flag simply becomes reachable.
   if (DIGITS < min_digits(WIDTH, SIGNED != 0)) begin : g_digits_chk
      $warning("bin_bcd_seq: DIGITS=%0d cannot hold every WIDTH=%0d magnitude; overflow reachable",
               DIGITS, WIDTH);
   end

   bin_bcd_state_t          state_q, state_d;
   logic [WIDTH-1:0]        mag_q;
   logic                    sign_q;
   logic [4*DIGITS-1:0]     work_q;
   logic                    ovf_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    done_q;
   logic [4*DIGITS-1:0]     bcd_q;
   logic                    neg_q;
   logic                    ovf_out_q;
   logic [DIGITS-1:0]       blank_q, blank_d;

   logic                    accept, shifting, finishing;
   logic                    sign_in;
   logic [WIDTH-1:0]        mag_in;
   logic [4*DIGITS-1:0]     work_shift;
   logic [DIGITS:0]         carry;
   logic                    zero_hi;

   // Operand magnitude: the most negative value maps to 2^(WIDTH-1) unsigned.
   assign sign_in = (SIGNED != 0) && in[WIDTH-1];
   assign mag_in  = sign_in ? (~in + WIDTH'(1)) : in;

   // Digit chain, units first; the operand MSB feeds the units digit.
   assign carry[0] = mag_q[WIDTH-1];
   for (genvar k = 0; k < DIGITS; k++) begin : g_cell
      bcd_dabble_cell u_cell (
         .digit_i (work_q[4*k +: 4]),
         .shift_i (carry[k]),
         .digit_o (work_shift[4*k +: 4]),
         .shift_o (carry[k+1])
      );
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: one SHIFT cycle per operand bit, then one DONE cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)         state_d = SHIFT;
         SHIFT:   if (cnt_q == '0)   state_d = DONE;
         DONE:                       state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // FSM outputs: handshake and datapath enables.
   always_comb begin
      ready     = (state_q == IDLE);
      accept    = (state_q == IDLE) && start;
      shifting  = (state_q == SHIFT);
      finishing = (state_q == DONE);
   end

   // Leading-zero blanking from the finished digits; units digit always shown.
   always_comb begin
      blank_d = '0;
      zero_hi = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_hi    = zero_hi & (work_q[4*k +: 4] == 4'd0);
         blank_d[k] = zero_hi;
      end
      blank_d[0] = 1'b0;
   end

   // Operand latch, shift engine and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mag_q     <= '0;
         sign_q    <= 1'b0;
         work_q    <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         neg_q     <= 1'b0;
         ovf_out_q <= 1'b0;
         blank_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            mag_q  <= mag_in;
            sign_q <= sign_in;
            work_q <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= CNT_LAST;
         end else if (shifting) begin
            mag_q  <= mag_q << 1;
            work_q <= work_shift;
            ovf_q  <= ovf_q | carry[DIGITS];
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
         end
         if (finishing) begin
            bcd_q     <= work_q;
            neg_q     <= sign_q;
            ovf_out_q <= ovf_q;
            blank_q   <= blank_d;
            done_q    <= 1'b1;
         end
      end
   end

   assign done     = done_q;
   assign bcd      = bcd_q;
   assign negative = neg_q;
   assign overflow = ovf_out_q;
`ifdef BIN_BCD_SEQ_BLANK_EN
   assign blank    = blank_q;
`endif

endmodule
